vga_timing_gen: RTL and testbench

//  - Generates 640x480 VGA raster timing: hcount, vcount, bright, hsync, vsync.
//  - Sits directly upstream of the tile colour-selection stage, which consumes hcount/vcount/bright.
//  - Also drives the board's sync pins.
//  - Pixel rate is derived from the system clock with an internal clock-enable divider.
//  - There is no second clock domain.

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing generator with an internal pixel clock-enable divider.
// Optional frame counter output is enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_TOTAL  = 800,
   parameter int H_SYNC   = 96,
   parameter int H_LEFT   = 144,
   parameter int H_ACTIVE = 640,
   parameter int V_TOTAL  = 521,
   parameter int V_SYNC   = 2,
   parameter int V_TOP    = 31,
   parameter int V_ACTIVE = 480
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       hsync,
   output logic       vsync,
   output logic       bright,
   output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
   localparam logic [9:0] H_START   = 10'(H_LEFT);
   localparam logic [9:0] H_END     = 10'(H_LEFT + H_ACTIVE);
   localparam logic [9:0] V_START   = 10'(V_TOP);
   localparam logic [9:0] V_END     = 10'(V_TOP + V_ACTIVE);

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_en_q, pix_en_d;
   logic [9:0]       hcount_q, hcount_d;
   logic [9:0]       vcount_q, vcount_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             bright_q, bright_d;
   logic             frame_start_q, frame_start_d;
   logic             h_wrap, v_wrap;

   // Divider: pix_en is registered, so it lands one clk after div reaches its last value.
   always_comb begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      pix_en_d = (div_q == DIV_LAST);
   end

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      h_wrap        = (hcount_q == H_LAST);
      v_wrap        = (vcount_q == V_LAST);
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      frame_start_d = 1'b0;
      if (pix_en_q) begin
         hcount_d = h_wrap ? '0 : hcount_q + 10'd1;
         if (h_wrap) begin
            vcount_d      = v_wrap ? '0 : vcount_q + 10'd1;
            frame_start_d = v_wrap;
         end
      end
   end

   // Decode from the next counts so the registered outputs line up with the registered counts.
   always_comb begin
      hsync_d  = ~(hcount_d < H_SYNC_W);
      vsync_d  = ~(vcount_d < V_SYNC_W);
      bright_d = (hcount_d >= H_START) && (hcount_d < H_END) &&
                 (vcount_d >= V_START) && (vcount_d < V_END);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         pix_en_q      <= 1'b0;
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         bright_q      <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         pix_en_q      <= pix_en_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         bright_q      <= bright_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pix_en      = pix_en_q;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign bright      = bright_q;
   assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size DUT (CLK_DIV=2) and a shrunken-raster DUT (CLK_DIV=1) checked every clk
// against a closed-form raster model indexed by clks since reset release.
module tb_vga_timing_gen;

   // Shrunken raster for the second DUT so many frames fit in a short run.
   localparam int B_HT = 20, B_HSY = 3, B_HL = 5, B_HA = 10;
   localparam int B_VT = 12, B_VSY = 2, B_VTP = 3, B_VA = 6;

   logic clk = 1'b0;
   logic rst_a, rst_b;

   logic       pix_en_a, hsync_a, vsync_a, bright_a, frame_start_a;
   logic [9:0] hcount_a, vcount_a;
   logic       pix_en_b, hsync_b, vsync_b, bright_b, frame_start_b;
   logic [9:0] hcount_b, vcount_b;
   logic [15:0] frame_cnt_a, frame_cnt_b;

   int tests_run = 0;
   int tests_failed = 0;
   int n_a = 0;
   int n_b = 0;
   logic [40:0] q_a[$];
   logic [40:0] q_b[$];

   always #5 clk = ~clk;

   vga_timing_gen #(.CLK_DIV(2)) dut_a (
      .clk(clk), .rst(rst_a), .pix_en(pix_en_a), .hcount(hcount_a), .vcount(vcount_a),
      .hsync(hsync_a), .vsync(vsync_a), .bright(bright_a), .frame_start(frame_start_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(frame_cnt_a)
`endif
   );

   vga_timing_gen #(.CLK_DIV(1), .H_TOTAL(B_HT), .H_SYNC(B_HSY), .H_LEFT(B_HL), .H_ACTIVE(B_HA),
                    .V_TOTAL(B_VT), .V_SYNC(B_VSY), .V_TOP(B_VTP), .V_ACTIVE(B_VA)) dut_b (
      .clk(clk), .rst(rst_b), .pix_en(pix_en_b), .hcount(hcount_b), .vcount(vcount_b),
      .hsync(hsync_b), .vsync(vsync_b), .bright(bright_b), .frame_start(frame_start_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(frame_cnt_b)
`endif
   );

`ifndef VGA_TIMING_FRAME_CNT_EN
   assign frame_cnt_a = '0;
   assign frame_cnt_b = '0;
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Expected outputs after n rising edges since reset release.
   // Result layout: {frame_cnt[15:0], pix_en, hcount[9:0], vcount[9:0], hsync, vsync, bright, frame_start}
   function automatic logic [40:0] model(input int n, input int d, input int ht, input int hsy,
                                         input int hl, input int ha, input int vt, input int vsy,
                                         input int vtp, input int va);
      int pix, h, v, frame;
      logic pe, hs, vs, br, fs;
      pe    = (n > 0) && (n % d == 0);
      pix   = (n > 0) ? (n - 1) / d : 0;
      frame = ht * vt;
      h     = pix % ht;
      v     = (pix / ht) % vt;
      hs    = (h >= hsy);
      vs    = (v >= vsy);
      br    = (h >= hl) && (h < hl + ha) && (v >= vtp) && (v < vtp + va);
      fs    = (pix > 0) && ((n - 1) % d == 0) && (pix % frame == 0);
      return {16'(pix / frame), pe, 10'(h), 10'(v), hs, vs, br, fs};
   endfunction

   // Stimulus side: every edge advances the clock index and queues the expected outputs.
   always @(posedge clk) begin
      n_a = rst_a ? 0 : n_a + 1;
      n_b = rst_b ? 0 : n_b + 1;
      q_a.push_back(model(n_a, 2, 800, 96, 144, 640, 521, 2, 31, 480));
      q_b.push_back(model(n_b, 1, B_HT, B_HSY, B_HL, B_HA, B_VT, B_VSY, B_VTP, B_VA));
   end

   // Output side: compare away from the active edge.
   always @(negedge clk) begin
      logic [40:0] e;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
`ifdef VGA_TIMING_FRAME_CNT_EN
         check("sb_a", {frame_cnt_a, pix_en_a, hcount_a, vcount_a, hsync_a, vsync_a, bright_a,
                        frame_start_a}, e);
`else
         check("sb_a", {pix_en_a, hcount_a, vcount_a, hsync_a, vsync_a, bright_a, frame_start_a},
               e[24:0]);
`endif
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
`ifdef VGA_TIMING_FRAME_CNT_EN
         check("sb_b", {frame_cnt_b, pix_en_b, hcount_b, vcount_b, hsync_b, vsync_b, bright_b,
                        frame_start_b}, e);
`else
         check("sb_b", {pix_en_b, hcount_b, vcount_b, hsync_b, vsync_b, bright_b, frame_start_b},
               e[24:0]);
`endif
      end
   end

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Covers hsync edges, the full bright line at vcount 31 and lands on (400,32).
      repeat (52001) @(negedge clk);
      check("pos_before_rst", {hcount_a, vcount_a}, {10'd400, 10'd32});

      #1;
      rst_a = 1'b1;
      #1;
      check("async_rst", {frame_cnt_a, pix_en_a, hcount_a, vcount_a, hsync_a, vsync_a, bright_a,
                          frame_start_a}, 41'd0);
      repeat (3) @(negedge clk);
      #1;
      rst_a = 1'b0;

      @(posedge clk);
      #1;
      check("rel_pix_en_1clk", {31'd0, pix_en_a}, 32'd0);
      @(posedge clk);
      #1;
      check("rel_pix_en_2clk", {31'd0, pix_en_a}, 32'd1);

      repeat (200) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
